// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state type and sizing helper for the restoring divider
package div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring iteration
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] p,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_p,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {p, q_msb};
  // The extra top bit of diff is the borrow: clear means the trial subtraction fits
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit   = ~diff[WIDTH+1];
  assign next_p  = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - sequential 2W/W restoring divider with valid/ready handshakes
// Define DIV_OVF_CHECK_EN to flag zero-divisor/overflow operands via err with a 1-cycle result.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem,
  output logic               err
);
  import div_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] p, q, dvs, step_p;
  logic             step_bit, accept, bad, last;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign last     = (state == RUN) && (count == CW'(1));

`ifdef DIV_OVF_CHECK_EN
  assign bad = (divisor == '0) || (dividend[2*WIDTH-1:WIDTH] >= divisor);
`else
  assign bad = 1'b0;
`endif

  // Only the low WIDTH bits of the partial remainder ever feed the next step
  div_step #(.WIDTH(WIDTH)) u_step (
    .p       (p),
    .q_msb   (q[WIDTH-1]),
    .divisor (dvs),
    .next_p  (step_p),
    .q_bit   (step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = bad ? DONE : RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p         <= '0;
      q         <= '0;
      dvs       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          p     <= dividend[2*WIDTH-1:WIDTH];
          q     <= dividend[WIDTH-1:0];
          dvs   <= divisor;
          count <= CW'(WIDTH);
          err   <= bad;
          if (bad) begin
            out_valid <= 1'b1;
            quot      <= '1;
            rem       <= '0;
          end
        end
        RUN: begin
          p     <= step_p;
          q     <= {q[WIDTH-2:0], step_bit};
          count <= count - CW'(1);
          if (last) begin
            out_valid <= 1'b1;
            quot      <= {q[WIDTH-2:0], step_bit};
            rem       <= step_p;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - directed and random checks of seq_restoring_divider (WIDTH=4)
module tb_seq_restoring_divider;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   quot, rem;
  logic           err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge
  task automatic issue(input logic [2*W-1:0] a, input logic [W-1:0] b);
    chk("in_ready_before_accept", 32'(in_ready), 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  // lat = number of rising edges from the accept edge to the first edge that sees out_valid
  task automatic wait_result(output int lat);
    lat = 1;
    chk("in_ready_busy", 32'(in_ready), 0);
    while (out_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("result_timeout", 32'(out_valid), 1);
  endtask

  task automatic expect_ok(input string tag, input int a, input int b);
    int lat;
    wait_result(lat);
    chk({tag, "_latency"}, 32'(lat), W + 1);
    chk({tag, "_quot"}, 32'(quot), a / b);
    chk({tag, "_rem"}, 32'(rem), a % b);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_identity"}, 32'(int'(quot) * b + int'(rem)), a);
    chk({tag, "_rem_lt_div"}, 32'(int'(rem) < b), 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    chk("out_valid_after_hs", 32'(out_valid), 0);
    chk("in_ready_after_hs", 32'(in_ready), 1);
  endtask

  initial begin
    int lat, ib, hi, lo, a, d;

    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk("reset_quot", 32'(quot), 0);
    chk("reset_rem", 32'(rem), 0);
    chk("reset_err", 32'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic op and latency
    out_ready = 1'b0;
    issue(8'd143, 4'd11);
    expect_ok("t1", 143, 11);
    handshake();

    // Back-to-back with out_ready held high
    issue(8'd100, 4'd7);
    expect_ok("t2a", 100, 7);
    handshake();
    issue(8'd225, 4'd15);
    expect_ok("t2b", 225, 15);
    handshake();

    // Back-pressure: result held, in_valid ignored
    out_ready = 1'b0;
    issue(8'd15, 4'd1);
    expect_ok("t3", 15, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      dividend = 8'($urandom);
      divisor  = 4'($urandom_range(1, 15));
      @(negedge clk);
      chk("t3_hold_valid", 32'(out_valid), 1);
      chk("t3_hold_quot", 32'(quot), 15);
      chk("t3_hold_rem", 32'(rem), 0);
      chk("t3_hold_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    handshake();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_kept_quot", 32'(quot), 15);
    chk("t3_kept_rem", 32'(rem), 0);
    chk("t3_no_new_op", 32'(out_valid), 0);

`ifdef DIV_OVF_CHECK_EN
    issue(8'd50, 4'd0);
    wait_result(lat);
    chk("t4_zero_latency", 32'(lat), 1);
    chk("t4_zero_err", 32'(err), 1);
    chk("t4_zero_quot", 32'(quot), 15);
    chk("t4_zero_rem", 32'(rem), 0);
    handshake();
    out_ready = 1'b0;
    issue(8'd200, 4'd3);
    wait_result(lat);
    chk("t4_ovf_latency", 32'(lat), 1);
    chk("t4_ovf_err", 32'(err), 1);
    handshake();
    out_ready = 1'b0;
`endif

    // Reset mid-RUN aborts the op
    issue(8'd143, 4'd11);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", 32'(out_valid), 0);
    chk("t5_rst_in_ready", 32'(in_ready), 1);
    chk("t5_rst_quot", 32'(quot), 0);
    chk("t5_rst_rem", 32'(rem), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'd143, 4'd11);
    expect_ok("t5_after", 143, 11);
    handshake();

    // Random in-range operations against plain integer division
    for (int n = 0; n < 1000; n++) begin
      out_ready = 1'b0;
      ib = int'($urandom_range(1, 15));
      hi = int'($urandom_range(0, ib - 1));
      lo = int'($urandom_range(0, 15));
      a  = hi * 16 + lo;
      issue(8'(a), 4'(ib));
      expect_ok("rand", a, ib);
      d = int'($urandom_range(0, 2));
      repeat (d) @(negedge clk);
      handshake();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
